// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: imem request/response, execute redirect and decode hand-off.
// master = fetch stage side, slave = memory/execute/decode environment side.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic        instr_valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid_d, instr_d, pc_d,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall_d
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid_d, instr_d, pc_d,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall_d
  );
endinterface

// File: rtl/fetch_stage.sv
// Small generic FIFO with flush; used for the PC tag queue and the instruction buffer.
// Latency: pushed entry visible at head the cycle after push.
// Backpressure: push ignored when full unless a pop frees a slot the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

// Instruction fetch: PC, in-order imem requests, response buffer feeding decode; optional FETCH_PERF_CNT_EN counters.
// Latency: request accepted in cycle N -> instr_valid_d in N+2; 1 instr/cycle sustained.
// Backpressure: stall_d holds the buffer head; requests stop once in-flight + buffered reach BUF_DEPTH.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_dropped,
`endif
  fetch_stage_if.master fe
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_word_t;

  logic [31:0]      pc_f_q, pc_f_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] outstanding, occupancy;
  logic [CNT_W:0]   in_use;
  logic [31:0]      tag_pc;
  fetch_word_t      buf_push_dat, buf_head;
  logic             credit_ok, req_accept, rsp_retire, rsp_drop, buf_push;
  logic             instr_vld, pop;
  logic [1:0]       unused_redirect_lsbs;

  assign instr_vld = (occupancy != '0);
  assign pop       = instr_vld & ~fe.stall_d;

  // A pop this cycle frees a slot early so a full pipe keeps streaming.
  assign in_use    = {1'b0, outstanding} + {1'b0, occupancy} - (CNT_W+1)'(pop);
  assign credit_ok = in_use < (CNT_W+1)'(BUF_DEPTH);

  assign fe.imem_req_valid = ~rst & ~fe.redirect_valid & credit_ok;
  assign fe.imem_req_addr  = pc_f_q;
  assign req_accept        = fe.imem_req_valid & fe.imem_req_ready;

  // Responses with nothing outstanding are protocol violations and are ignored.
  assign rsp_retire = fe.imem_rsp_valid & (outstanding != '0);
  assign rsp_drop   = rsp_retire & (fe.redirect_valid | (drop_cnt_q != '0));
  assign buf_push   = rsp_retire & ~rsp_drop;

  assign buf_push_dat = {fe.imem_rsp_data, tag_pc};

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (BUF_DEPTH)
  ) u_tag_q (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (1'b0),
    .push_i     (req_accept),
    .push_dat_i (pc_f_q),
    .pop_i      (rsp_retire),
    .head_dat_o (tag_pc),
    .count_o    (outstanding)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_word_t)),
    .DEPTH (BUF_DEPTH)
  ) u_instr_buf (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (fe.redirect_valid),
    .push_i     (buf_push),
    .push_dat_i (buf_push_dat),
    .pop_i      (pop),
    .head_dat_o (buf_head),
    .count_o    (occupancy)
  );

  assign fe.instr_valid_d = instr_vld;
  assign fe.instr_d       = instr_vld ? buf_head.instr : '0;
  assign fe.pc_d          = instr_vld ? buf_head.pc    : '0;

  always_comb begin
    pc_f_d     = pc_f_q;
    drop_cnt_d = drop_cnt_q;
    if (fe.redirect_valid) begin
      pc_f_d     = {fe.redirect_pc[31:2], 2'b00};
      // Every request still in flight after this cycle belongs to the old path.
      drop_cnt_d = outstanding - CNT_W'(rsp_retire);
    end else begin
      if (req_accept) pc_f_d = pc_f_q + 32'd4;
      if (rsp_drop)   drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q     <= {RESET_PC[31:2], 2'b00};
      drop_cnt_q <= '0;
    end else begin
      pc_f_q     <= pc_f_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign unused_redirect_lsbs = fe.redirect_pc[1:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;

  // The head presented during a redirect is discarded by decode, so it counts as dropped.
  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop & ~fe.redirect_valid);
    perf_dropped_d = perf_dropped_q + 32'(rsp_drop)
                   + (fe.redirect_valid ? 32'(occupancy) : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model plus a PC-stream reference (sequential from reset/redirect target).
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] DAT_XOR   = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic clk = 1'b0;
  logic rst;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .fe  (bus)
  );

  always #5 clk = ~clk;

  mreq_t       mq[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  int          lat_min, lat_max, rsp_pct, bogus_pct;
  logic [31:0] exp_pc, exp_req_pc;
  logic        s_rv, s_iv, s_acc;
  logic [31:0] s_ra, s_id, s_ipc;
  int          pop_cnt = 0;
  logic [31:0] last_pop_pc;
  int          first_acc, first_iv;
  bit          prev_req_wait, prev_hold;
  logic [31:0] prev_addr, prev_id, prev_ipc;

  task automatic check_dat(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ DAT_XOR;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.stall_d        = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    #1;
    check_dat("rst_req_vld_now", 32'(bus.imem_req_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_dat("rst_req_vld", 32'(bus.imem_req_valid), 32'd0);
    check_dat("rst_instr_vld", 32'(bus.instr_valid_d), 32'd0);
    check_dat("rst_instr", bus.instr_d, 32'd0);
    check_dat("rst_pc", bus.pc_d, 32'd0);
    check_dat("rst_req_addr", bus.imem_req_addr, RESET_PC);
    rst = 1'b0;
    mq.delete();
    exp_pc        = RESET_PC;
    exp_req_pc    = RESET_PC;
    prev_req_wait = 1'b0;
    prev_hold     = 1'b0;
    first_acc     = -1;
    first_iv      = -1;
  endtask

  // One clock: drive inputs, sample outputs, check against the stream model, advance.
  task automatic tick(input bit redir, input logic [31:0] tgt, input bit stall, input bit rdy);
    bit rsp_taken;
    int inflight_next;
    rsp_taken = 1'b0;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.stall_d        = stall;
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (mq.size() > 0) begin
      if (mq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = word_of(mq[0].addr);
        rsp_taken          = 1'b1;
      end
    end else if ($urandom_range(99) < bogus_pct) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = $urandom;
    end
    #1;
    s_rv  = bus.imem_req_valid;
    s_ra  = bus.imem_req_addr;
    s_iv  = bus.instr_valid_d;
    s_id  = bus.instr_d;
    s_ipc = bus.pc_d;
    s_acc = s_rv & rdy;

    if (redir) check_dat("no_req_on_redirect", 32'(s_rv), 32'd0);
    if (prev_req_wait) check_dat("req_addr_held", s_ra, prev_addr);
    if (s_acc) begin
      check_dat("req_addr", s_ra, exp_req_pc);
      exp_req_pc    = exp_req_pc + 32'd4;
      inflight_next = mq.size() - int'(rsp_taken) + 1;
      check_dat("credit_limit", 32'(inflight_next <= BUF_DEPTH), 32'd1);
      mq.push_back('{addr: s_ra, due: cyc + 1 + int'($urandom_range(lat_max, lat_min))});
    end
    if (redir) exp_req_pc = {tgt[31:2], 2'b00};

    if (prev_hold) begin
      check_dat("hold_vld", 32'(s_iv), 32'd1);
      check_dat("hold_instr", s_id, prev_id);
      check_dat("hold_pc", s_ipc, prev_ipc);
    end
    if (!s_iv) begin
      check_dat("idle_instr", s_id, 32'd0);
      check_dat("idle_pc", s_ipc, 32'd0);
    end else if (!redir && !stall) begin
      check_dat("pop_pc", s_ipc, exp_pc);
      check_dat("pop_instr", s_id, word_of(exp_pc));
      last_pop_pc = s_ipc;
      pop_cnt++;
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) exp_pc = {tgt[31:2], 2'b00};

    if (s_acc && first_acc < 0) first_acc = cyc;
    if (s_iv && first_iv < 0) first_iv = cyc;
    prev_req_wait = s_rv & ~rdy;
    prev_addr     = s_ra;
    prev_hold     = s_iv & stall & ~redir;
    prev_id       = s_id;
    prev_ipc      = s_ipc;

    @(posedge clk);
    cyc++;
    if (rsp_taken) void'(mq.pop_front());
    @(negedge clk);
  endtask

  task automatic wait_pop(input string tag, input int budget);
    int start;
    bit seen;
    start = pop_cnt;
    seen  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1'b0, '0, 1'b0, 1'b1);
      if (pop_cnt != start) seen = 1'b1;
    end
    check_dat(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  found;
    int  redir_pct, stall_pct, rdy_pct;

    lat_min   = 0;
    lat_max   = 0;
    rsp_pct   = 100;
    bogus_pct = 0;
    do_reset();

    // Zero-wait memory: back-to-back requests, 2-cycle first latency, 1 instr/cycle.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, 1'b0, 1'b1);
      check_dat("t1_accept", 32'(s_acc), 32'd1);
      check_dat("t1_addr", s_ra, RESET_PC + 32'(i * 4));
    end
    repeat (3) tick(1'b0, '0, 1'b0, 1'b1);
    check_dat("t1_latency", 32'(first_iv - first_acc), 32'd2);
    n = 0;
    repeat (10) begin
      tick(1'b0, '0, 1'b0, 1'b1);
      n += int'(s_iv);
    end
    check_dat("t1_throughput", 32'(n), 32'd10);

    // Decode stall: head holds, fetch stops on credits, clean resume.
    for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b1, 1'b1);
    check_dat("t2_req_blocked", 32'(s_rv), 32'd0);
    repeat (8) tick(1'b0, '0, 1'b0, 1'b1);

    // Redirect with two fetches in flight.
    lat_min = 1;
    lat_max = 1;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq.size() == 2) found = 1'b1;
      else tick(1'b0, '0, 1'b0, 1'b1);
    end
    check_dat("t3_two_inflight", 32'(found), 32'd1);
    tick(1'b1, 32'h0000_0100, 1'b0, 1'b1);
    wait_pop("t3_resume", 20);
    check_dat("t3_first_pc", last_pop_pc, 32'h0000_0100);

    // Back-to-back redirects.
    repeat (4) tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b1, 32'h0000_0200, 1'b0, 1'b1);
    tick(1'b1, 32'h0000_0300, 1'b0, 1'b1);
    wait_pop("t4_resume", 20);
    check_dat("t4_first_pc", last_pop_pc, 32'h0000_0300);

    // Memory not ready: address held at 0x40 until accepted.
    repeat (6) tick(1'b0, '0, 1'b0, 1'b0);
    check_dat("t5_drained", 32'(mq.size()), 32'd0);
    tick(1'b1, 32'h0000_0040, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, 1'b0, 1'b0);
      check_dat("t5_wait_vld", 32'(s_rv), 32'd1);
      check_dat("t5_wait_addr", s_ra, 32'h0000_0040);
    end
    tick(1'b0, '0, 1'b0, 1'b1);
    check_dat("t5_accept", 32'(s_acc), 32'd1);
    check_dat("t5_accept_addr", s_ra, 32'h0000_0040);
    tick(1'b0, '0, 1'b0, 1'b1);
    check_dat("t5_next_addr", s_ra, 32'h0000_0044);

    // Unaligned redirect target and PC wrap.
    tick(1'b1, 32'h0000_0103, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b1);
    check_dat("t6_align", s_ra, 32'h0000_0100);
    repeat (4) tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, '0, 1'b0, 1'b1);
      found = s_acc;
    end
    check_dat("t6_wrap_accept", 32'(found), 32'd1);
    check_dat("t6_wrap_hi", s_ra, 32'hFFFF_FFFC);
    tick(1'b0, '0, 1'b0, 1'b1);
    check_dat("t6_wrap_lo", s_ra, 32'h0000_0000);
    repeat (6) tick(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic, including stray responses and a mid-stream reset.
    for (int r = 0; r < 4; r++) begin
      lat_min   = 0;
      lat_max   = int'($urandom_range(3));
      rsp_pct   = int'($urandom_range(100, 40));
      bogus_pct = 10;
      redir_pct = int'($urandom_range(8, 1));
      stall_pct = int'($urandom_range(50));
      rdy_pct   = int'($urandom_range(100, 30));
      for (int k = 0; k < 600; k++) begin
        tick($urandom_range(99) < redir_pct, $urandom,
             $urandom_range(99) < stall_pct, $urandom_range(99) < rdy_pct);
      end
      if (r == 1) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
